// File: rtl/line_mem_responder.sv
// Line-granular backing memory for the cache's lower mem_itf port.
// Serves one whole-line read or write at a time, answering after a fixed latency.
module line_mem_responder #(
    parameter int s_offset = 5,
    parameter int s_line   = 8 * (2 ** s_offset),
    parameter int s_depth  = 10,
    parameter int LATENCY  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [s_line-1:0] mem_wdata,
    output logic [s_line-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              error
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int DEPTH = 2 ** s_depth;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;

    logic [s_depth-1:0]   idx_r;
    logic                 op_read_r;
    logic                 oor_r;
    logic [s_line-1:0]    wdata_r;

    logic [s_line-1:0]    rdata_r;
    logic                 resp_r;
    logic                 error_r;

    logic                 req_s;
    logic                 req_oor_s;
    logic                 req_conflict_s;
    logic [s_depth-1:0]   req_idx_s;
    logic                 accept_s;

    logic                 fill_s;
    logic                 fill_read_s;
    logic                 fill_oor_s;
    logic [s_depth-1:0]   fill_idx_s;
    logic                 commit_s;
    logic                 resp_s;

    // Zero contents at elaboration; reset deliberately leaves the array alone.
    logic [s_line-1:0]    mem_array [DEPTH] = '{default: '0};

    // Decode the incoming request: line index, range check, read/write conflict.
    always_comb begin
        req_s          = mem_read | mem_write;
        req_idx_s      = mem_address[s_offset +: s_depth];
        req_oor_s      = ((mem_address >> (s_offset + s_depth)) != 32'd0);
        req_conflict_s = mem_read & mem_write;
        accept_s       = (state_r == IDLE) && req_s;
    end

    // Next-state and latency-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_s = (LATENCY == 1) ? RESP : BUSY;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            end
            BUSY: begin
                if (cnt_r <= CNT_W'(1)) begin
                    state_s = RESP;
                    cnt_s   = '0;
                end else begin
                    state_s = BUSY;
                    cnt_s   = cnt_r - CNT_W'(1);
                end
            end
            RESP: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Output-side decode: array read on entry to RESP, array write on exit.
    // With LATENCY=1 RESP is entered straight from IDLE, so the live request
    // must be used instead of the not-yet-captured copy.
    always_comb begin
        fill_s = (state_s == RESP) && (state_r != RESP);
        if (state_r == IDLE) begin
            fill_read_s = mem_read;
            fill_oor_s  = req_oor_s;
            fill_idx_s  = req_idx_s;
        end else begin
            fill_read_s = op_read_r;
            fill_oor_s  = oor_r;
            fill_idx_s  = idx_r;
        end
        commit_s = (state_r == RESP) && !op_read_r && !oor_r;
        resp_s   = (state_s == RESP);
    end

    // State, counter, response pulse and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            resp_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            resp_r  <= resp_s;
            if (accept_s && (req_conflict_s || req_oor_s)) begin
                error_r <= 1'b1;
            end
        end
    end

    // Capture the accepted request; a read+write conflict is serviced as a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r     <= '0;
            op_read_r <= 1'b0;
            oor_r     <= 1'b0;
            wdata_r   <= '0;
        end else if (accept_s) begin
            idx_r     <= req_idx_s;
            op_read_r <= mem_read;
            oor_r     <= req_oor_s;
            wdata_r   <= mem_wdata;
        end
    end

    // Read-data register: only a completing read updates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= '0;
        end else if (fill_s && fill_read_s) begin
            rdata_r <= fill_oor_s ? '0 : mem_array[fill_idx_s];
        end
    end

    // Array write port; a reset during RESP suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && commit_s) begin
            mem_array[idx_r] <= wdata_r;
        end
    end

    assign mem_rdata = rdata_r;
    assign mem_resp  = resp_r;
    assign error     = error_r;

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_line_mem_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr  [2];
    logic         rd    [2];
    logic         wr    [2];
    logic [255:0] wdata [2];
    logic [255:0] rdata [2];
    logic         resp  [2];
    logic         err   [2];
    logic         prev_resp [2];

    int cyc    = 0;
    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        int           dut;
        int           cyc;
        logic [255:0] data;
        logic         err;
    } exp_t;

    exp_t sb [$];

    line_mem_responder #(.LATENCY(4)) dut_a (
        .clk(clk), .rst(rst), .mem_address(addr[0]), .mem_read(rd[0]),
        .mem_write(wr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
        .mem_resp(resp[0]), .error(err[0])
    );

    line_mem_responder #(.LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .mem_address(addr[1]), .mem_read(rd[1]),
        .mem_write(wr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
        .mem_resp(resp[1]), .error(err[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: every response must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (resp[d]) begin
                if (sb.size() == 0 || sb[0].dut != d) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_resp dut%0d at cycle %0d", d, cyc);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("resp_cycle dut%0d", d), 256'(cyc), 256'(e.cyc));
                    chk($sformatf("rdata dut%0d cyc%0d", d, cyc), rdata[d], e.data);
                    chk($sformatf("error dut%0d cyc%0d", d, cyc), 256'(err[d]), 256'(e.err));
                end
                chk($sformatf("resp_not_consecutive dut%0d", d), 256'(prev_resp[d]), 256'(0));
            end
            prev_resp[d] <= resp[d];
        end
    end

    task automatic issue(input int d, input logic [31:0] a, input logic r, input logic w,
                         input logic [255:0] wd, input logic [255:0] exp_d, input logic exp_e);
        exp_t e;
        bit   seen;
        @(posedge clk);
        #1;
        addr[d]  = a;
        rd[d]    = r;
        wr[d]    = w;
        wdata[d] = wd;
        e.dut  = d;
        e.cyc  = cyc + lat(d);
        e.data = exp_d;
        e.err  = exp_e;
        sb.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (resp[d]) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_fail++;
            $display("FAIL resp_timeout dut%0d addr %h: got none expected mem_resp", d, a);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
        end
    endtask

    task automatic reset_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_error", 256'(err[0]), 256'(0));
        chk("reset_rdata", rdata[0], 256'(0));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            addr[d]  = 32'd0;
            rd[d]    = 1'b0;
            wr[d]    = 1'b0;
            wdata[d] = 256'd0;
            prev_resp[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("init_resp dut%0d", d), 256'(resp[d]), 256'(0));
            chk($sformatf("init_rdata dut%0d", d), rdata[d], 256'(0));
            chk($sformatf("init_error dut%0d", d), 256'(err[d]), 256'(0));
        end

        // Write index 3 then read it back immediately.
        issue(0, 32'h60, 1'b0, 1'b1, {32{8'hA5}}, 256'd0, 1'b0);
        issue(0, 32'h60, 1'b1, 1'b0, 256'd0, {32{8'hA5}}, 1'b0);
        // Unwritten line, offset bits ignored, rdata held over a write.
        issue(0, 32'hE0, 1'b1, 1'b0, 256'd0, 256'd0, 1'b0);
        issue(0, 32'hFF, 1'b1, 1'b0, 256'd0, 256'd0, 1'b0);
        issue(0, 32'h7F, 1'b1, 1'b0, 256'd0, {32{8'hA5}}, 1'b0);
        issue(0, 32'h120, 1'b0, 1'b1, {32{8'h3C}}, {32{8'hA5}}, 1'b0);
        issue(0, 32'h120, 1'b1, 1'b0, 256'd0, {32{8'h3C}}, 1'b0);
        // Read+write conflict: serviced as a read, error sticky, no write.
        issue(0, 32'h40, 1'b1, 1'b1, {32{8'hFF}}, 256'd0, 1'b1);
        issue(0, 32'h40, 1'b1, 1'b0, 256'd0, 256'd0, 1'b1);
        reset_all();
        // Out-of-range read and write.
        issue(0, 32'h0001_0000, 1'b1, 1'b0, 256'd0, 256'd0, 1'b1);
        reset_all();
        issue(0, 32'h0, 1'b0, 1'b1, {32{8'h5A}}, 256'd0, 1'b0);
        issue(0, 32'h0001_0000, 1'b0, 1'b1, {32{8'hFF}}, 256'd0, 1'b1);
        issue(0, 32'h0, 1'b1, 1'b0, 256'd0, {32{8'h5A}}, 1'b1);
        reset_all();
        // Reset during the BUSY phase of a write.
        issue(0, 32'h20, 1'b0, 1'b1, {32{8'h77}}, 256'd0, 1'b0);
        issue(0, 32'h20, 1'b1, 1'b0, 256'd0, {32{8'h77}}, 1'b0);
        @(posedge clk);
        #1;
        addr[0]  = 32'h20;
        rd[0]    = 1'b0;
        wr[0]    = 1'b1;
        wdata[0] = {32{8'hEE}};
        @(posedge clk);
        #1;
        rst   = 1'b1;
        wr[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_resp", 256'(resp[0]), 256'(0));
        chk("abort_rdata", rdata[0], 256'(0));
        chk("abort_error", 256'(err[0]), 256'(0));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_resp", 256'(resp[0]), 256'(0));
        end
        issue(0, 32'h20, 1'b1, 1'b0, 256'd0, {32{8'h77}}, 1'b0);
        idle();

        // LATENCY=1: fill indices 0..15, then back-to-back reads.
        for (int k = 0; k < 16; k++) begin
            issue(1, 32'(k) << 5, 1'b0, 1'b1, {32{8'(k + 1)}}, 256'd0, 1'b0);
        end
        for (int k = 0; k < 16; k++) begin
            issue(1, 32'(k) << 5, 1'b1, 1'b0, 256'd0, {32{8'(k + 1)}}, 1'b0);
        end
        idle();

        repeat (8) @(negedge clk);
        chk("scoreboard_drained", 256'(sb.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
